prbs7_checker: RTL and testbench
================================

Name: prbs7_checker

Overview:
- Serial PRBS7 receiver/checker for the pipeline test designs. It consumes the single-bit stream that leaves a chain of data_path stages.
- It self-synchronises to the pattern, declares lock, then counts bit errors so that timing/retiming defects in the chain show up as observable mismatches.
- It is the receiving end of a PRBS7 stimulus source driving the chain input.

Parameters:
- LOCK_COUNT, 16, consecutive matching bits required in VERIFY before declaring lock (>=1)
- WINDOW, 128, length in valid bits of the error-monitoring window while locked (>=2)
- UNLOCK_ERRORS, 4, errors within one window that force loss of lock (>=1, <=WINDOW)
- ERR_W, 16, width of the saturating error counter

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  in is a valid stream bit this cycle
- in  input  1  received serial bit
- clear  input  1  synchronous clear of err_count (does not affect lock)
- locked  output  1  checker is locked to the PRBS7 sequence
- err  output  1  one-cycle pulse: mismatch on a valid bit while locked
- err_count  output  ERR_W  saturating count of errors while locked

Behaviour:
- Polynomial x^7+x^6+1: b[n] = b[n-7] ^ b[n-6]. A 7-bit history register hist holds the last 7 bits; hist[0] is newest. expected = hist[6] ^ hist[5].
- All state changes only on cycles with en=1, except clear and reset. With en=0 the block holds all state, and err=0.
- Reset (async assert, any state, mid-lock included):
  - state=SEED, hist=0, seed/match/window/window-error counters=0
  - locked=0, err=0, err_count=0
- SEED:
  - hist <= {hist[5:0], in}; count valid bits.
  - After the 7th valid bit, go to VERIFY with match counter=0.
- VERIFY:
  - hist shifts in the received bit.
  - in==expected: match counter +1. When it reaches LOCK_COUNT, go to LOCKED. locked=1 from the next cycle.
  - in!=expected: match counter=0, stay in VERIFY (self-resync; history already holds the received bits).
  - hist==0 at any valid bit (all-zero lockup): go to SEED, seed counter=0.
- LOCKED:
  - hist free-runs: hist <= {hist[5:0], expected}. The received bit is not shifted in, so a single flipped bit counts as exactly one error.
  - in!=expected: err=1 the following cycle (registered, one cycle); err_count +1, saturating at 2^ERR_W-1; window error counter +1.
  - Window counter counts valid bits 0..WINDOW-1 and wraps. On wrap, the window error counter resets to 0. If the bit that wraps is itself an error, it counts into the closing window first.
  - When the window error counter reaches UNLOCK_ERRORS: go to SEED, locked=0 next cycle, hist/counters cleared. err_count is retained.
- clear:
  - err_count <= 0 that cycle.
  - clear and an error in the same cycle: err_count = 1, because the error wins over the cleared value.
  - clear has no effect on state, locked or err.
- Latency: err and locked are registered, one cycle after the deciding valid bit.
- No errors are counted outside LOCKED.

Test Plan:
- Reset, then clean PRBS7 from seed 7'h7F with en=1 continuously -> locked=0 through bit 23; locked=1 the cycle after the 23rd bit (7 seed + 16 match); err stays 0 and err_count=0 over 1000 bits.
- Locked, invert bit 50 only -> exactly one err pulse one cycle later; err_count=1; locked stays 1; no further errors.
- Locked, flip 4 bits within one 128-bit window -> err_count=4; locked=0 the cycle after the 4th error. Clean stream resumed -> relock 23 valid bits later, err_count still 4.
- Constant in=0 after reset -> after 7 bits hist==0 returns to SEED repeatedly; locked never asserts; err_count=0.
- Locked, en toggling 1/0 every cycle with clean data -> lock held, no err; en=0 cycles ignore garbage on in.
- ERR_W=4, locked with UNLOCK_ERRORS=WINDOW and continuous errors -> err_count saturates at 15. clear together with an error -> 1. Async rst pulse mid-lock -> locked=0, err_count=0 immediately without a clock edge.

Source files
------------

// File: rtl/prbs7_checker.sv
// Serial PRBS7 (x^7+x^6+1) checker: self-synchronises to the incoming stream,
// declares lock, then counts bit errors with windowed loss-of-lock detection.
module prbs7_checker #(
    parameter int LOCK_COUNT    = 16,
    parameter int WINDOW        = 128,
    parameter int UNLOCK_ERRORS = 4,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int UE_W    = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [UE_W-1:0]    UE_LAST    = UE_W'(UNLOCK_ERRORS - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    typedef enum logic [1:0] {S_SEED, S_VERIFY, S_LOCKED} state_t;

    state_t             state, state_nxt;
    logic [6:0]         hist;
    logic [2:0]         seed_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [UE_W-1:0]    win_err;

    logic expected, mism, hist_zero, seed_done, match_done, unlock, wrap, err_event;

    assign expected   = hist[6] ^ hist[5];
    assign mism       = in ^ expected;
    assign hist_zero  = (hist == 7'd0);
    assign seed_done  = (seed_cnt == 3'd6);
    assign match_done = !mism && (match_cnt == MATCH_LAST);
    assign unlock     = mism && (win_err == UE_LAST);
    assign wrap       = (win_cnt == WIN_LAST);
    assign err_event  = en && (state == S_LOCKED) && mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SEED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            unique case (state)
                S_SEED:   if (seed_done) state_nxt = S_VERIFY;
                S_VERIFY: begin
                    if (hist_zero)       state_nxt = S_SEED;
                    else if (match_done) state_nxt = S_LOCKED;
                end
                S_LOCKED: if (unlock) state_nxt = S_SEED;
                default:  state_nxt = S_SEED;
            endcase
        end
    end

    always_comb begin
        locked = (state == S_LOCKED);
    end

    // History and counters; while locked the history free-runs on its own
    // prediction so one flipped input bit costs exactly one error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (en) begin
            unique case (state)
                S_SEED: begin
                    hist      <= {hist[5:0], in};
                    seed_cnt  <= seed_done ? 3'd0 : seed_cnt + 3'd1;
                    match_cnt <= '0;
                end
                S_VERIFY: begin
                    if (hist_zero) begin
                        hist      <= '0;
                        seed_cnt  <= '0;
                        match_cnt <= '0;
                    end else begin
                        hist      <= {hist[5:0], in};
                        match_cnt <= (mism || match_done) ? '0 : match_cnt + MATCH_W'(1);
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end
                end
                S_LOCKED: begin
                    if (unlock) begin
                        hist      <= '0;
                        seed_cnt  <= '0;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end else begin
                        hist    <= {hist[5:0], expected};
                        win_cnt <= wrap ? '0 : win_cnt + WIN_W'(1);
                        win_err <= wrap ? '0 : win_err + UE_W'(mism);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= err_event;
            if (clear)
                err_count <= err_event ? ERR_W'(1) : '0;
            else if (err_event && err_count != ERR_MAX)
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Randomised bench for prbs7_checker: a default instance and a narrow-counter
// instance share stimulus and are compared against a bit-level reference model.
module tb_prbs7_checker;

    localparam int LOCKN = 16;
    localparam int WIN   = 128;

    logic clk = 1'b0;
    logic rst, en, in, clear;
    logic locked, err;
    logic [15:0] err_count;
    logic locked2, err2;
    logic [3:0] err_count2;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .clear(clear),
        .locked(locked), .err(err), .err_count(err_count)
    );

    prbs7_checker #(.LOCK_COUNT(16), .WINDOW(128), .UNLOCK_ERRORS(128), .ERR_W(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in(in), .clear(clear),
        .locked(locked2), .err(err2), .err_count(err_count2)
    );

    typedef struct {
        int       mode;   // 0 seeding, 1 verifying, 2 locked
        int       seedn;
        int       matchn;
        int       winn;
        int       winerr;
        int       errcnt;
        bit       err;
        bit       locked;
        bit [6:0] h;
    } model_t;

    model_t m1, m2;
    int     asserts  = 0;
    int     failures = 0;
    bit     prbs[127];
    int     pidx = 0;

    function automatic model_t mreset();
        model_t m;
        m.mode = 0; m.seedn = 0; m.matchn = 0; m.winn = 0; m.winerr = 0;
        m.errcnt = 0; m.err = 0; m.locked = 0; m.h = '0;
        return m;
    endfunction

    function automatic model_t step(model_t mi, bit v, bit b, bit clr, int errmax, int unl);
        model_t m = mi;
        bit e;
        m.err = 0;
        if (clr) m.errcnt = 0;
        if (v) begin
            e = m.h[6] ^ m.h[5];
            case (m.mode)
                0: begin
                    m.h = {m.h[5:0], b};
                    m.seedn++;
                    if (m.seedn == 7) begin m.mode = 1; m.seedn = 0; m.matchn = 0; end
                end
                1: begin
                    if (m.h == 0) begin
                        m.mode = 0; m.seedn = 0;
                    end else begin
                        m.h = {m.h[5:0], b};
                        if (b == e) begin
                            m.matchn++;
                            if (m.matchn == LOCKN) begin
                                m.mode = 2; m.matchn = 0; m.winn = 0; m.winerr = 0;
                            end
                        end else m.matchn = 0;
                    end
                end
                default: begin
                    if (b != e) begin
                        m.err = 1;
                        m.winerr++;
                        if (m.errcnt < errmax) m.errcnt++;
                    end
                    m.h = {m.h[5:0], e};
                    m.winn++;
                    if (m.winerr == unl) begin
                        m.mode = 0; m.h = '0; m.seedn = 0; m.matchn = 0; m.winn = 0; m.winerr = 0;
                    end else if (m.winn == WIN) begin
                        m.winn = 0; m.winerr = 0;
                    end
                end
            endcase
        end
        m.locked = (m.mode == 2);
        return m;
    endfunction

    task automatic tick(input bit v, input bit b, input bit clr);
        en = v; in = b; clear = clr;
        @(posedge clk);
        m1 = step(m1, v, b, clr, 65535, 4);
        m2 = step(m2, v, b, clr, 15, 128);
        #1;
    endtask

    task automatic next_bit(output bit b);
        b = prbs[pidx];
        pidx = (pidx + 1) % 127;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in = 1'b0; clear = 1'b0;
        #1;
        m1 = mreset(); m2 = mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_up();
        bit b;
        for (int k = 0; k < 23; k++) begin next_bit(b); tick(1, b, 0); end
    endtask

    task automatic test_reset();
        do_reset();
        asserts++;
        if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL reset dut locked=%b err=%b cnt=%0d, want 0/0/0", locked, err, err_count);
        end
        asserts++;
        if (locked2 !== 1'b0 || err2 !== 1'b0 || err_count2 !== 4'd0) begin
            failures++;
            $display("FAIL reset dut2 locked=%b err=%b cnt=%0d, want 0/0/0", locked2, err2, err_count2);
        end
    endtask

    task automatic test_clean_lock();
        bit b;
        for (int k = 1; k <= 1000; k++) begin
            next_bit(b); tick(1, b, 0);
            asserts++;
            if (locked !== (k >= 23)) begin
                failures++;
                $display("FAIL clean_lock bit %0d locked=%b want %b", k, locked, k >= 23);
            end
            asserts++;
            if (err !== 1'b0 || err_count !== 16'd0) begin
                failures++;
                $display("FAIL clean_err bit %0d err=%b cnt=%0d want 0/0", k, err, err_count);
            end
        end
    endtask

    task automatic test_single_flip();
        bit b;
        for (int k = 1; k <= 200; k++) begin
            next_bit(b); tick(1, (k == 50) ? ~b : b, 0);
            asserts++;
            if (err !== (k == 50) || locked !== 1'b1) begin
                failures++;
                $display("FAIL single_flip bit %0d err=%b locked=%b want %b/1", k, err, locked, k == 50);
            end
        end
        asserts++;
        if (err_count !== 16'd1) begin
            failures++;
            $display("FAIL single_flip_count cnt=%0d want 1", err_count);
        end
    endtask

    task automatic test_unlock_relock();
        bit b;
        bit f;
        int n;
        next_bit(b); tick(1, b, 1);
        asserts++;
        if (err_count !== 16'd0) begin
            failures++;
            $display("FAIL clear cnt=%0d want 0", err_count);
        end
        for (int g = 0; g < 200 && m1.winn != 0; g++) begin next_bit(b); tick(1, b, 0); end
        for (int k = 1; k <= 11; k++) begin
            f = (k == 2 || k == 5 || k == 8 || k == 11);
            next_bit(b); tick(1, f ? ~b : b, 0);
            asserts++;
            if (locked !== (k < 11) || err !== f) begin
                failures++;
                $display("FAIL burst bit %0d locked=%b err=%b want %b/%b", k, locked, err, k < 11, f);
            end
        end
        asserts++;
        if (err_count !== 16'd4) begin
            failures++;
            $display("FAIL burst_count cnt=%0d want 4", err_count);
        end
        n = 0;
        while (!locked && n < 100) begin next_bit(b); tick(1, b, 0); n++; end
        asserts++;
        if (n !== 23 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL relock bits=%0d cnt=%0d want 23/4", n, err_count);
        end
    endtask

    task automatic test_zero_stream();
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            tick(1, 0, 0);
            asserts++;
            if (locked !== 1'b0 || err_count !== 16'd0 || err !== 1'b0) begin
                failures++;
                $display("FAIL zero_stream bit %0d locked=%b cnt=%0d want 0/0", k, locked, err_count);
            end
        end
    endtask

    task automatic test_en_toggle();
        bit b;
        do_reset();
        lock_up();
        for (int k = 0; k < 200; k++) begin
            if (k % 2 == 0) begin next_bit(b); tick(1, b, 0); end
            else tick(0, 1'($urandom_range(0, 1)), 0);
            asserts++;
            if (locked !== 1'b1 || err !== 1'b0 || err_count !== 16'd0) begin
                failures++;
                $display("FAIL en_toggle cyc %0d locked=%b err=%b cnt=%0d want 1/0/0", k, locked, err, err_count);
            end
        end
    endtask

    task automatic test_random();
        bit b, v, c;
        for (int k = 0; k < 3000; k++) begin
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 149) == 0);
            if (v) begin
                next_bit(b);
                if ($urandom_range(0, 39) == 0) b = ~b;
            end else b = 1'($urandom_range(0, 1));
            tick(v, b, c);
            asserts++;
            if (locked !== m1.locked || err !== m1.err || err_count !== 16'(m1.errcnt)) begin
                failures++;
                $display("FAIL random cyc %0d dut %b/%b/%0d want %b/%b/%0d", k,
                         locked, err, err_count, m1.locked, m1.err, m1.errcnt);
            end
            asserts++;
            if (locked2 !== m2.locked || err2 !== m2.err || err_count2 !== 4'(m2.errcnt)) begin
                failures++;
                $display("FAIL random2 cyc %0d dut2 %b/%b/%0d want %b/%b/%0d", k,
                         locked2, err2, err_count2, m2.locked, m2.err, m2.errcnt);
            end
        end
    endtask

    task automatic test_saturation();
        bit b;
        do_reset();
        lock_up();
        for (int k = 1; k <= 40; k++) begin
            next_bit(b); tick(1, ~b, 0);
            asserts++;
            if (locked2 !== 1'b1 || err2 !== 1'b1 || err_count2 !== 4'((k < 15) ? k : 15)) begin
                failures++;
                $display("FAIL saturate bit %0d locked=%b err=%b cnt=%0d want 1/1/%0d",
                         k, locked2, err2, err_count2, (k < 15) ? k : 15);
            end
        end
        next_bit(b); tick(1, ~b, 1);
        asserts++;
        if (err_count2 !== 4'd1 || locked2 !== 1'b1) begin
            failures++;
            $display("FAIL clear_with_err cnt=%0d locked=%b want 1/1", err_count2, locked2);
        end
        rst = 1'b1;
        #1;
        asserts++;
        if (locked2 !== 1'b0 || err_count2 !== 4'd0 || err2 !== 1'b0 ||
            locked !== 1'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL async_reset locked2=%b cnt2=%0d err2=%b locked=%b cnt=%0d want all 0",
                     locked2, err_count2, err2, locked, err_count);
        end
        m1 = mreset(); m2 = mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 7; n++) prbs[n] = 1'b1;
        for (int n = 7; n < 127; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];
        rst = 1'b1; en = 1'b0; in = 1'b0; clear = 1'b0;
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_unlock_relock();
        test_zero_stream();
        test_en_toggle();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
